detector_paso: RTL and testbench

//  Direction detector for the two-beam passage sensor pair. Consumes the debounced sensor

---
 rtl/detector_paso_pkg.sv | 31 +++
 rtl/detector_paso_temporizador.sv | 37 +++
 rtl/detector_paso.sv | 153 +++++++++++++++
 tb/tb_detector_paso.sv | 169 ++++++++++++++++
 4 files changed

// File: rtl/detector_paso_pkg.sv
// -----------------------------------------------------------------------------
// detector_paso_pkg
//   Shared definitions for the two-beam passage direction detector:
//   - estado_t    : the eight FSM state codes (also exported on the estado port)
//   - SAL_ENTRADA : salida bit carrying the entry pulse (drives z1)
//   - SAL_SALIDA  : salida bit carrying the exit pulse (drives z2)
//   - TIMEOUT_CYC_DEF : default maximum dwell in one non-idle state, in cycles
// -----------------------------------------------------------------------------
package detector_paso_pkg;

    typedef enum logic [2:0] {
        IDLE   = 3'b000,
        ENT_A  = 3'b001,
        ENT_AB = 3'b010,
        ENT_B  = 3'b011,
        SAL_B  = 3'b100,
        SAL_AB = 3'b101,
        SAL_A  = 3'b110,
        ESPERA = 3'b111
    } estado_t;

    localparam int SAL_ENTRADA     = 0;
    localparam int SAL_SALIDA      = 1;
    localparam int TIMEOUT_CYC_DEF = 50_000_000;

    // True for the six states that belong to an ongoing crossing.
    function automatic logic en_cruce(input estado_t s);
        return (s != IDLE) && (s != ESPERA);
    endfunction

endpackage

// File: rtl/detector_paso_temporizador.sv
// -----------------------------------------------------------------------------
// temporizador_paso
//   Dwell-time counter for the passage detector. Counts cycles spent in the
//   current state; the FSM clears it on every state change.
// Ports
//   clk     in  system clock
//   reset   in  synchronous, active-high; clears the count
//   clr     in  clear request (has priority over en)
//   en      in  count enable
//   vencido out high while count == TIMEOUT_CYC-1
// -----------------------------------------------------------------------------
module temporizador_paso #(
    parameter int TIMEOUT_CYC = 50_000_000
) (
    input  logic clk,
    input  logic reset,
    input  logic clr,
    input  logic en,
    output logic vencido
);

    localparam int CNT_W = $clog2(TIMEOUT_CYC + 1);
    localparam logic [CNT_W-1:0] LIMITE = CNT_W'(TIMEOUT_CYC - 1);

    logic [CNT_W-1:0] cuenta;

    always_ff @(posedge clk) begin
        if (reset || clr) begin
            cuenta <= '0;
        end else if (en) begin
            cuenta <= cuenta + CNT_W'(1);
        end
    end

    assign vencido = (cuenta == LIMITE);

endmodule

// File: rtl/detector_paso.sv
// -----------------------------------------------------------------------------
// detector_paso
//   Direction detector for the two-beam passage sensor pair. Follows the
//   AB level sequence (A = outer beam, B = inner beam) and emits a one-cycle
//   entry or exit pulse when a full crossing completes. Aborted, ambiguous
//   and stalled crossings are rejected; ambiguous or stalled ones park in
//   ESPERA until both beams are clear.
// Ports
//   clk      in   system clock
//   reset    in   synchronous, active-high
//   A, B     in   debounced beam levels, 1 = interrupted, synchronous to clk
//   estado   out  current state code
//   salida   out  [SAL_ENTRADA] entry pulse, [SAL_SALIDA] exit pulse
//   error    out  one-cycle pulse on entering ESPERA
//   ocupado  out  high whenever estado != IDLE
// -----------------------------------------------------------------------------
module detector_paso
    import detector_paso_pkg::*;
#(
    parameter int TIMEOUT_CYC = TIMEOUT_CYC_DEF
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       A,
    input  logic       B,
    output logic [2:0] estado,
    output logic [1:0] salida,
    output logic       error,
    output logic       ocupado
);

    estado_t     state, trans, state_next;
    logic [1:0]  ab;
    logic [1:0]  salida_n;
    logic        vencido;
    logic        t_clr;
    logic        t_en;

    assign ab = {A, B};

    temporizador_paso #(
        .TIMEOUT_CYC(TIMEOUT_CYC)
    ) u_temporizador (
        .clk    (clk),
        .reset  (reset),
        .clr    (t_clr),
        .en     (t_en),
        .vencido(vencido)
    );

    // The count always describes the dwell in the state being entered, so it
    // is cleared by the same edge that changes state.
    assign t_clr = (state_next != state) || !en_cruce(state);
    assign t_en  = en_cruce(state);

    always_comb begin
        trans    = state;
        salida_n = 2'b00;
        unique case (state)
            IDLE: begin
                case (ab)
                    2'b10:   trans = ENT_A;
                    2'b01:   trans = SAL_B;
                    2'b11:   trans = ESPERA;
                    default: trans = state;
                endcase
            end
            ENT_A: begin
                case (ab)
                    2'b11:   trans = ENT_AB;
                    2'b00:   trans = IDLE;
                    2'b01:   trans = ESPERA;
                    default: trans = state;
                endcase
            end
            ENT_AB: begin
                case (ab)
                    2'b01:   trans = ENT_B;
                    2'b10:   trans = ENT_A;
                    2'b00:   trans = ESPERA;
                    default: trans = state;
                endcase
            end
            ENT_B: begin
                case (ab)
                    2'b00: begin
                        trans                 = IDLE;
                        salida_n[SAL_ENTRADA] = 1'b1;
                    end
                    2'b11:   trans = ENT_AB;
                    2'b10:   trans = ESPERA;
                    default: trans = state;
                endcase
            end
            SAL_B: begin
                case (ab)
                    2'b11:   trans = SAL_AB;
                    2'b00:   trans = IDLE;
                    2'b10:   trans = ESPERA;
                    default: trans = state;
                endcase
            end
            SAL_AB: begin
                case (ab)
                    2'b10:   trans = SAL_A;
                    2'b01:   trans = SAL_B;
                    2'b00:   trans = ESPERA;
                    default: trans = state;
                endcase
            end
            SAL_A: begin
                case (ab)
                    2'b00: begin
                        trans                = IDLE;
                        salida_n[SAL_SALIDA] = 1'b1;
                    end
                    2'b11:   trans = SAL_AB;
                    2'b01:   trans = ESPERA;
                    default: trans = state;
                endcase
            end
            ESPERA: begin
                if (ab == 2'b00) begin
                    trans = IDLE;
                end
            end
            default: trans = IDLE;
        endcase

        // A real transition this cycle wins over an expiring dwell timer.
        state_next = trans;
        if ((trans == state) && vencido && en_cruce(state)) begin
            state_next = ESPERA;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= IDLE;
            salida  <= 2'b00;
            error   <= 1'b0;
            ocupado <= 1'b0;
        end else begin
            state   <= state_next;
            salida  <= salida_n;
            error   <= (state_next == ESPERA) && (state != ESPERA);
            ocupado <= (state_next != IDLE);
        end
    end

    assign estado = state;

endmodule

// File: tb/tb_detector_paso.sv
module tb_detector_paso;

    localparam int T = 16;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       A = 1'b0;
    logic       B = 1'b0;
    logic [2:0] estado;
    logic [1:0] salida;
    logic       error;
    logic       ocupado;

    always #5 clk = ~clk;

    detector_paso #(.TIMEOUT_CYC(T)) dut (
        .clk    (clk),
        .reset  (reset),
        .A      (A),
        .B      (B),
        .estado (estado),
        .salida (salida),
        .error  (error),
        .ocupado(ocupado)
    );

    // Expected {estado, salida, error, ocupado} after each clock edge.
    logic [6:0] exp_q[$];
    int n_cmp = 0;
    int n_err = 0;
    logic done = 1'b0;

    // Reference model: a crossing is a walk along a level sequence.
    // mode 0 = idle, 1 = entering, 2 = leaving, 3 = waiting for clear beams.
    int m_mode = 0;
    int m_pos = 0;
    int m_dwell = 0;
    logic [1:0] seq_ent [3] = '{2'b10, 2'b11, 2'b01};
    logic [1:0] seq_sal [3] = '{2'b01, 2'b11, 2'b10};

    function automatic logic [1:0] nivel(input int mode, input int pos);
        return (mode == 1) ? seq_ent[pos] : seq_sal[pos];
    endfunction

    task automatic model_step(input logic rst, input logic [1:0] ab);
        logic [1:0] pulse;
        logic       err;
        logic [2:0] code;
        pulse = 2'b00;
        err   = 1'b0;
        if (rst) begin
            m_mode = 0; m_pos = 0; m_dwell = 0;
        end else if (m_mode == 0) begin
            if (ab == 2'b10)      begin m_mode = 1; m_pos = 0; m_dwell = 0; end
            else if (ab == 2'b01) begin m_mode = 2; m_pos = 0; m_dwell = 0; end
            else if (ab == 2'b11) begin m_mode = 3; err = 1'b1; end
        end else if (m_mode == 3) begin
            if (ab == 2'b00) m_mode = 0;
        end else begin
            if (ab == nivel(m_mode, m_pos)) begin
                if (m_dwell == T - 1) begin m_mode = 3; err = 1'b1; end
                else m_dwell++;
            end else if (m_pos < 2 && ab == nivel(m_mode, m_pos + 1)) begin
                m_pos++; m_dwell = 0;
            end else if (m_pos == 2 && ab == 2'b00) begin
                pulse  = (m_mode == 1) ? 2'b01 : 2'b10;
                m_mode = 0;
            end else if (m_pos > 0 && ab == nivel(m_mode, m_pos - 1)) begin
                m_pos--; m_dwell = 0;
            end else if (m_pos == 0 && ab == 2'b00) begin
                m_mode = 0;
            end else begin
                m_mode = 3; err = 1'b1;
            end
        end
        case (m_mode)
            0:       code = 3'd0;
            1:       code = 3'(1 + m_pos);
            2:       code = 3'(4 + m_pos);
            default: code = 3'd7;
        endcase
        exp_q.push_back({code, pulse, err, (m_mode != 0)});
    endtask

    task automatic drive(input logic rst, input logic [1:0] ab, input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #2;
            reset = rst;
            {A, B} = ab;
            model_step(rst, ab);
        end
    endtask

    // Monitor: every edge produces one output sample to check.
    initial begin : monitor
        logic [6:0] e;
        logic [6:0] got;
        while (!done) begin
            @(posedge clk);
            #1;
            if (exp_q.size() > 0) begin
                e   = exp_q.pop_front();
                got = {estado, salida, error, ocupado};
                n_cmp++;
                if (got !== e) begin
                    n_err++;
                    $display("FAIL outputs t=%0t: got estado=%b salida=%b error=%b ocupado=%b, required estado=%b salida=%b error=%b ocupado=%b",
                             $time, got[6:4], got[3:2], got[1], got[0], e[6:4], e[3:2], e[1], e[0]);
                end
            end
        end
    end

    initial begin : stimulus
        logic [1:0] cur;
        int r;
        drive(1'b1, 2'b00, 3);
        // Entry crossing
        drive(1'b0, 2'b00, 3); drive(1'b0, 2'b10, 3); drive(1'b0, 2'b11, 3);
        drive(1'b0, 2'b01, 3); drive(1'b0, 2'b00, 3);
        // Exit crossing
        drive(1'b0, 2'b01, 3); drive(1'b0, 2'b11, 3); drive(1'b0, 2'b10, 3);
        drive(1'b0, 2'b00, 3);
        // Backtrack then abort
        drive(1'b0, 2'b10, 3); drive(1'b0, 2'b11, 3); drive(1'b0, 2'b10, 3);
        drive(1'b0, 2'b00, 3);
        // Illegal jump, then release
        drive(1'b0, 2'b10, 2); drive(1'b0, 2'b01, 3); drive(1'b0, 2'b00, 3);
        // Both beams at once from idle
        drive(1'b0, 2'b11, 2); drive(1'b0, 2'b00, 2);
        // Timeout in ENT_A, and a transition exactly at the limit in SAL_B
        drive(1'b0, 2'b10, 20); drive(1'b0, 2'b00, 3);
        drive(1'b0, 2'b01, T); drive(1'b0, 2'b11, 2); drive(1'b0, 2'b10, 2);
        drive(1'b0, 2'b00, 2);
        // Reset in ENT_B
        drive(1'b0, 2'b10, 2); drive(1'b0, 2'b11, 2); drive(1'b0, 2'b01, 2);
        drive(1'b1, 2'b01, 1); drive(1'b0, 2'b00, 4);
        // Randomised walk
        cur = 2'b00;
        for (int k = 0; k < 3000; k++) begin
            r = $urandom_range(0, 99);
            if (r < 2) begin
                drive(1'b1, cur, 1);
            end else if (r < 62) begin
                cur[$urandom_range(0, 1)] ^= 1'b1;
                drive(1'b0, cur, $urandom_range(1, 4));
            end else if (r < 72) begin
                drive(1'b0, cur, $urandom_range(10, 20));
            end else begin
                cur = 2'($urandom_range(0, 3));
                drive(1'b0, cur, $urandom_range(1, 3));
            end
        end
        drive(1'b0, 2'b00, 3);
        @(posedge clk);
        @(posedge clk);
        #3;
        done = 1'b1;
        n_cmp++;
        if (exp_q.size() != 0) begin
            n_err++;
            $display("FAIL drain: %0d expected samples left unchecked, required 0", exp_q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
